// File: rtl/rle_video_stream_pkg.sv
// Shared types and word-field helpers for the run-length video decoder.
package rle_video_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_DESYNC   = 1;

    // Words are passed widened to 64 bits so one helper serves any RUN_W/COLOUR_W.
    function automatic logic [31:0] word_run(input logic [63:0] word, input int run_w,
                                             input int colour_w);
        logic [63:0] mask;
        mask = (64'd1 << run_w) - 64'd1;
        return 32'((word >> colour_w) & mask);
    endfunction

    function automatic logic [31:0] word_colour(input logic [63:0] word, input int colour_w);
        logic [63:0] mask;
        mask = (64'd1 << colour_w) - 64'd1;
        return 32'(word & mask);
    endfunction

endpackage

// File: rtl/rle_video_stream_fifo.sv
// Synchronous prefetch FIFO with flush; pointers wrap naturally (DEPTH is a power of two).
module rle_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rle_video_stream.sv
// Run-length video decoder: prefetch FIFO feeding a per-pixel colour FSM with sticky error flags.
module rle_video_stream
    import rle_video_pkg::*;
#(
    parameter int                   COLOUR_W        = 6,
    parameter int                   RUN_W           = 10,
    parameter int                   DEPTH           = 4,
    parameter logic [COLOUR_W-1:0]  UNDERRUN_COLOUR = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RUN_W+COLOUR_W-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        stop_data,
    input  logic                        next_frame,
    input  logic                        next_pixel,
    output logic [COLOUR_W-1:0]         colour,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic [1:0]                  err
);
    localparam int WORD_W = RUN_W + COLOUR_W;

    state_t              state;
    logic [RUN_W-1:0]    run_cnt;
    logic [WORD_W-1:0]   head;
    logic [RUN_W-1:0]    head_run;
    logic [COLOUR_W-1:0] head_colour;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    assign in_ready    = (state != IDLE) && !fifo_full;
    assign stop_data   = (state == IDLE);
    assign push        = in_valid && in_ready;
    assign head_run    = RUN_W'(word_run(64'(head), RUN_W, COLOUR_W));
    assign head_colour = COLOUR_W'(word_colour(64'(head), COLOUR_W));

    rle_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (state == IDLE),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // A desync next_frame in RUN suppresses the pixel pop of the same cycle.
    always_comb begin
        pop = 1'b0;
        unique case (state)
            FILL:    pop = next_frame && !fifo_empty;
            RUN:     pop = next_pixel && !next_frame && (run_cnt == RUN_W'(1)) && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
            colour  <= '0;
            err     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    colour <= '0;
                    state  <= FILL;
                end
                FILL: begin
                    if (next_frame) begin
                        if (fifo_empty) begin
                            err[ERR_UNDERRUN] <= 1'b1;
                        end else if (head_run == '0) begin
                            colour <= '0;
                            state  <= IDLE;
                        end else begin
                            run_cnt <= head_run;
                            colour  <= head_colour;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (next_frame) begin
                        err[ERR_DESYNC] <= 1'b1;
                        state           <= IDLE;
                    end else if (next_pixel) begin
                        if (run_cnt > RUN_W'(1)) begin
                            run_cnt <= run_cnt - 1'b1;
                        end else if (fifo_empty) begin
                            colour            <= UNDERRUN_COLOUR;
                            err[ERR_UNDERRUN] <= 1'b1;
                        end else if (head_run == '0) begin
                            colour <= '0;
                            state  <= IDLE;
                        end else begin
                            run_cnt <= head_run;
                            colour  <= head_colour;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_video_stream.sv
// Scoreboard bench: pixel colours expected from run expansion of each frame, checked per strobe.
module tb_rle_video_stream;
    localparam int             CW = 6;
    localparam int             RW = 10;
    localparam int             D  = 4;
    localparam logic [CW-1:0]  UC = 6'h07;

    logic            clk = 1'b0;
    logic            rst;
    logic [RW+CW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            stop_data;
    logic            next_frame;
    logic            next_pixel;
    logic [CW-1:0]   colour;
    logic [$clog2(D):0] fifo_level;
    logic [1:0]      err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [RW+CW-1:0] src_q[$];
    logic [CW-1:0]    exp_q[$];

    always #5 clk = ~clk;

    rle_video_stream #(
        .COLOUR_W        (CW),
        .RUN_W           (RW),
        .DEPTH           (D),
        .UNDERRUN_COLOUR (UC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .stop_data  (stop_data),
        .next_frame (next_frame),
        .next_pixel (next_pixel),
        .colour     (colour),
        .fifo_level (fifo_level),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW+CW-1:0] word(input int r, input int c);
        return {RW'(r), CW'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [CW-1:0] e);
        exp_q.push_back(e);
        next_pixel = 1'b1;
        tick();
        next_pixel = 1'b0;
    endtask

    task automatic nf();
        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
    endtask

    task automatic wait_level(input int lvl);
        int n = 0;
        while (int'(fifo_level) != lvl && n < 50) begin
            tick();
            n++;
        end
        check("wait_level", 32'(fifo_level), lvl);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_q.delete();
        tick();
        tick();
        check("rst_colour", 32'(colour), 0);
        check("rst_err", 32'(err), 0);
        check("rst_level", 32'(fifo_level), 0);
        rst = 1'b0;
        check("idle_stop", 32'(stop_data), 1);
        check("idle_ready", 32'(in_ready), 0);
        tick();
        check("fill_stop", 32'(stop_data), 0);
        check("fill_ready", 32'(in_ready), 1);
    endtask

    // Source: presents the head of src_q, retires it on a sampled handshake.
    initial begin
        logic take;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            take = in_valid && in_ready && !rst;
            @(posedge clk);
            if (take && src_q.size() > 0) void'(src_q.pop_front());
            #1;
            in_valid = (src_q.size() > 0);
            in_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    // Monitor: each pixel strobe shows the colour of that pixel.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && next_pixel) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pixel: unexpected strobe, got %0h expected none", colour);
                end else begin
                    check("pixel", 32'(colour), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int n;
        int runs[$];
        int cols[$];
        rst        = 1'b1;
        next_frame = 1'b0;
        next_pixel = 1'b0;
        do_reset();
        check("rst_colour_after", 32'(colour), 0);

        // Basic decode; the fifth pixel runs dry.
        src_q.push_back(word(3, 'h15));
        src_q.push_back(word(2, 'h2A));
        wait_level(2);
        nf();
        check("first_colour", 32'(colour), 'h15);
        px(6'h15); px(6'h15); px(6'h15); px(6'h2A); px(6'h2A);
        check("basic_err", 32'(err), 1);
        check("basic_uc", 32'(colour), 32'(UC));

        // End-of-frame marker.
        do_reset();
        src_q.push_back(word(1, 'h3F));
        src_q.push_back(word(0, 'h2C));
        wait_level(2);
        nf();
        px(6'h3F);
        check("eof_stop", 32'(stop_data), 1);
        check("eof_colour", 32'(colour), 0);
        px(6'h00);
        check("eof_stop_low", 32'(stop_data), 0);
        check("eof_level", 32'(fifo_level), 0);
        check("eof_ready", 32'(in_ready), 1);
        check("eof_err", 32'(err), 0);

        // Underrun and recovery.
        do_reset();
        src_q.push_back(word(2, 'h11));
        wait_level(1);
        nf();
        px(6'h11);
        px(6'h11);
        check("ur_err", 32'(err), 1);
        px(UC);
        src_q.push_back(word(1, 'h22));
        wait_level(1);
        px(UC);
        check("ur_recover", 32'(colour), 'h22);

        // Backpressure, then desync.
        do_reset();
        src_q.push_back(word(5, 'h01));
        for (int i = 2; i <= 6; i++) src_q.push_back(word(1, i));
        repeat (10) tick();
        check("bp_level", 32'(fifo_level), 4);
        check("bp_ready", 32'(in_ready), 0);
        check("bp_taken", src_q.size(), 2);
        nf();
        check("bp_pop_level", 32'(fifo_level), 3);
        check("bp_colour", 32'(colour), 1);
        tick();
        check("bp_refill", 32'(fifo_level), 4);
        check("bp_taken2", src_q.size(), 1);
        nf();
        src_q.delete();
        check("ds_err", 32'(err), 2);
        check("ds_stop", 32'(stop_data), 1);
        check("ds_ready", 32'(in_ready), 0);
        tick();
        check("ds_stop_low", 32'(stop_data), 0);
        check("ds_flushed", 32'(fifo_level), 0);
        src_q.push_back(word(2, 'h09));
        src_q.push_back(word(0, 0));
        wait_level(2);
        nf();
        px(6'h09);
        px(6'h09);
        check("ds_restart_eof", 32'(stop_data), 1);
        check("ds_err_kept", 32'(err), 2);
        tick();

        // Random frames; the first carries the maximum run length.
        do_reset();
        for (int f = 0; f < 20; f++) begin
            runs.delete();
            cols.delete();
            n = $urandom_range(0, 5);
            if (f == 0) begin
                runs.push_back((1 << RW) - 1);
                cols.push_back($urandom_range(0, 63));
            end
            for (int i = 0; i < n; i++) begin
                runs.push_back($urandom_range(1, 4));
                cols.push_back($urandom_range(0, 63));
            end
            for (int i = 0; i < runs.size(); i++) src_q.push_back(word(runs[i], cols[i]));
            src_q.push_back(word(0, $urandom_range(0, 63)));
            wait_level((runs.size() + 1 < D) ? runs.size() + 1 : D);
            nf();
            for (int i = 0; i < runs.size(); i++) begin
                for (int k = 0; k < runs[i]; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    px(CW'(cols[i]));
                end
            end
            check("rand_eof", 32'(stop_data), 1);
            tick();
        end
        check("rand_err", 32'(err), 0);
        tick();
        check("exp_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rle_video_stream.md
Name: rle_video_stream

Overview:
- Parametrised run-length video decoder with a prefetch FIFO.
- Sits between the streaming data source (flash/SPI reader) and the VGA timing/colour output stage.
- Each input word carries {run, colour}. The block emits colour per pixel strobe, buffers upcoming words to absorb source latency, and supports an explicit end-of-frame marker.
- Adds underrun and frame-desync detection as sticky error flags.

Parameters:
- COLOUR_W, 6, colour field width in bits.
- RUN_W, 10, run-length field width in bits.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- UNDERRUN_COLOUR, 0, colour driven while starved of data (COLOUR_W bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  RUN_W+COLOUR_W  word: [RUN_W+COLOUR_W-1:COLOUR_W] = run, [COLOUR_W-1:0] = colour.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO accepts a word; transfer when in_valid && in_ready.
- stop_data  out  1  high in IDLE; source must restart its stream from frame start.
- next_frame  in  1  single-cycle strobe, start of frame.
- next_pixel  in  1  single-cycle strobe, advance one pixel.
- colour  out  COLOUR_W  current pixel colour, registered.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- err  out  2  sticky: [0] underrun, [1] frame desync; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state <= IDLE; FIFO emptied; run counter 0; colour 0; err 0.
  - in_ready=0; stop_data=1.
- States: IDLE -> FILL -> RUN -> IDLE.
- IDLE:
  - Lasts exactly one cycle.
  - FIFO flushed; stop_data=1; in_ready=0; colour <= 0.
  - Next state FILL.
- FILL:
  - FIFO accepts words; in_ready = (level < DEPTH).
  - On next_frame with FIFO non-empty:
    - Pop head word; run_cnt <= run; colour <= colour field; go RUN.
    - A head word with run=0 is an immediate end-of-frame: treat as below.
  - On next_frame with FIFO empty: err[0] <= 1; stay in FILL.
- RUN, on next_pixel:
  - run_cnt > 1: run_cnt <= run_cnt - 1.
  - run_cnt == 1, FIFO non-empty: pop; if popped run != 0, load run_cnt and colour.
  - run_cnt == 1, popped run == 0 (end-of-frame marker): colour <= 0; go IDLE.
  - run_cnt == 1, FIFO empty: colour <= UNDERRUN_COLOUR; err[0] <= 1; run_cnt stays 1.
    - Retry the pop on each later next_pixel.
    - The pixel in which a word arrives loads that word normally.
- RUN, no next_pixel: hold all state.
- next_frame while in RUN (desync):
  - err[1] <= 1; go IDLE; the next_pixel in the same cycle is ignored.
  - An end-of-frame pop in the same cycle also yields IDLE; err[1] still set.
- Latency: colour changes on the clk edge that samples next_pixel/next_frame; visible the following cycle.
- FIFO:
  - Push and pop in the same cycle allowed when not full; level unchanged.
  - When full, in_ready=0 even if popping that cycle (no combinational ready path).
  - Pointers wrap modulo DEPTH.
  - Words offered while in_ready=0 are not consumed.
- Arithmetic: run_cnt is RUN_W bits, never decremented below 1 in RUN. Max run is 2^RUN_W-1.
- fifo_level reflects occupancy after the current edge (registered).
- rst mid-frame: all of the above reset behaviour applies immediately; err cleared.

Decomposition:
- Package rle_video_pkg:
  - state enum {IDLE, FILL, RUN}.
  - err bit index constants ERR_UNDERRUN=0, ERR_DESYNC=1.
  - Functions word_run() and word_colour() extracting fields given RUN_W/COLOUR_W.
- Sub-module rle_fifo:
  - Synchronous FIFO, params WIDTH, DEPTH.
  - Ports push/pop/full/empty/level/flush.
- Top level holds the FSM, run counter, colour register and err flags.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> colour=0, err=0, stop_data=1 and in_ready=0 for 1 cycle, then stop_data=0 and in_ready=1.
- Basic decode: push {3,0x15},{2,0x2A}, pulse next_frame, then next_pixel on 5 consecutive cycles -> colour sequence 0x15,0x15,0x15,0x2A,0x2A.
- EOF marker: {1,0x3F},{0,any}; next_frame, 2 next_pixels -> colour 0x3F then 0; stop_data=1 for 1 cycle; fifo_level=0; in_ready high again next cycle.
- Underrun: only {2,0x11} supplied; 3 next_pixels -> 0x11,0x11,UNDERRUN_COLOUR and err=2'b01; then push {1,0x22} and pulse next_pixel -> colour 0x22.
- Backpressure: DEPTH=4, in_valid held 1, no next_frame -> exactly 4 transfers, fifo_level=4, in_ready=0; one pop with in_valid high -> level returns to 4 the following cycle.
- Desync: next_frame while run_cnt=5 in RUN -> err[1]=1, one IDLE cycle (stop_data=1, FIFO flushed), then FILL and a normal restart on the next next_frame.
